nanov_sequencer: RTL and testbench

Timing and control sequencer for the bit-serial nanoV core. It owns the instruction register and the bit counter (0..31) and the pass number (`cycle`), and drives these into the core. It decodes each instruction to set how many 32-clock passes it takes, and inserts a memory-transfer phase for loads and stores. It also handshakes with the instruction fetcher, inserting NOP bubbles when the fetcher is starved and flushing the fetcher when the core branches.

---
 rtl/nanov_sequencer.sv | 153 +++++++++++++++
 tb/tb_nanov_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_sequencer.sv
// nanov_sequencer: timing and control sequencer for the bit-serial nanoV core.
// Owns the instruction register, the bit counter (0..31) and the pass number,
// sizes each instruction in 32-clock passes, inserts the memory phase for
// loads/stores, and handshakes with the instruction fetcher.
module nanov_sequencer #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [29:0] fetch_data,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  output logic        fetch_flush,
  input  logic        branch,
  output logic [29:0] instr,
  output logic [29:0] next_instr,
  output logic [4:0]  counter,
  output logic [2:0]  cycle,
  output logic        shift_data_out,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        instr_retired
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_EXEC      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT  = 2'd2;
  localparam logic [1:0] ST_MEM_SHIFT = 2'd3;

  localparam logic [29:0] NOP_INSTR = NOP_WORD[31:2];

  logic [1:0]  state_q, state_d;
  logic [29:0] instr_q, instr_d;
  logic [4:0]  counter_q, counter_d;
  logic [2:0]  cycle_q, cycle_d;
  logic        bubble_q, bubble_d;
  logic        flush_q;

  // instr_q holds bits [31:2], so ISA bit k sits at index k-2.
  logic [4:0] opc;      // ISA bits [6:2]
  logic [1:0] f3_lo;    // ISA bits [13:12]
  assign opc   = instr_q[4:0];
  assign f3_lo = instr_q[11:10];

  logic is_jmp, is_branch, is_shift, is_load, is_store, is_mem;
  logic [2:0] last_pass;
  logic last_bit, mem_start, retire_slot;

  assign is_jmp    = (opc[4:2] == 3'b110) && opc[0];
  assign is_branch = (opc == 5'b11000);
  assign is_shift  = !opc[4] && opc[2] && (opc[1:0] == 2'b00) && (f3_lo == 2'b01);
  assign is_load   = (opc == 5'b00000);
  assign is_store  = (opc == 5'b01000);
  assign is_mem    = is_load || is_store;

  // Index of the final EXEC pass; stores never finish in EXEC.
  assign last_pass = is_load ? 3'd2 : (is_jmp || is_branch || is_shift) ? 3'd1 : 3'd0;

  assign last_bit    = (counter_q == 5'd31);
  assign mem_start   = is_mem && (cycle_q == 3'd0);
  assign retire_slot = last_bit &&
                       (((state_q == ST_EXEC) && !mem_start && (cycle_q >= last_pass)) ||
                        ((state_q == ST_MEM_SHIFT) && is_store));

  // Word the core would pick up at a consume clock; starved fetch yields a NOP.
  assign next_instr = fetch_valid ? fetch_data : NOP_INSTR;

  // In IDLE the flush clock must not swallow a stale prefetched word.
  assign fetch_ready    = ((state_q == ST_IDLE) && !flush_q) || retire_slot;
  assign instr_retired  = retire_slot && !bubble_q;
  assign mem_req        = (state_q == ST_MEM_WAIT);
  assign mem_we         = (state_q == ST_MEM_WAIT) && is_store;
  assign shift_data_out = (state_q == ST_MEM_SHIFT);
  assign fetch_flush    = flush_q;
  assign instr          = instr_q;
  assign counter        = counter_q;
  assign cycle          = cycle_q;

  // Next-state logic for sequencing state, counter, pass and instruction register.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    counter_d = counter_q;
    cycle_d   = cycle_q;
    bubble_d  = bubble_q;
    case (state_q)
      ST_IDLE: begin
        counter_d = 5'd0;
        cycle_d   = 3'd0;
        if (fetch_valid && !flush_q) begin
          instr_d  = fetch_data;
          bubble_d = 1'b0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        counter_d = counter_q + 5'd1;
        if (last_bit) begin
          if (mem_start) begin
            state_d   = ST_MEM_WAIT;
            cycle_d   = 3'd1;
            counter_d = 5'd0;
          end else if (retire_slot) begin
            instr_d  = next_instr;
            bubble_d = !fetch_valid;
            cycle_d  = 3'd0;
          end else begin
            cycle_d = cycle_q + 3'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        counter_d = 5'd0;
        cycle_d   = 3'd1;
        if (mem_ack) state_d = ST_MEM_SHIFT;
      end
      default: begin
        counter_d = counter_q + 5'd1;
        if (last_bit) begin
          state_d = ST_EXEC;
          if (is_load) begin
            cycle_d = 3'd2;
          end else begin
            instr_d  = next_instr;
            bubble_d = !fetch_valid;
            cycle_d  = 3'd0;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset; flush is branch delayed one clock.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      instr_q   <= NOP_INSTR;
      counter_q <= 5'd0;
      cycle_q   <= 3'd0;
      bubble_q  <= 1'b1;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
      bubble_q  <= bubble_d;
      flush_q   <= branch;
    end
  end

endmodule

// File: tb/tb_nanov_sequencer.sv
// Self-checking bench for nanov_sequencer: decode/latency table, hand-written
// corner sequences, and a randomized run against a timeline reference model.
module tb_nanov_sequencer;

  localparam logic [29:0] NOP30 = 30'h00000004; // 32'h13 >> 2

  logic        clk = 1'b0;
  logic        rstn;
  logic [29:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        fetch_flush;
  logic        branch;
  logic [29:0] instr;
  logic [29:0] next_instr;
  logic [4:0]  counter;
  logic [2:0]  cycle;
  logic        shift_data_out;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        instr_retired;

  nanov_sequencer dut (
    .clk(clk), .rstn(rstn),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_flush(fetch_flush), .branch(branch),
    .instr(instr), .next_instr(next_instr), .counter(counter), .cycle(cycle),
    .shift_data_out(shift_data_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: an instruction is a timeline of t = 0..len-1 bit clocks
  // (32 per pass/shift phase), with a memory wait inserted at t=32 for loads/stores.
  function automatic int m_len(input logic [29:0] w);
    logic [31:0] f;
    f = {w, 2'b11};
    if (f[6:2] == 5'b00000) return 96;
    if (f[6:2] == 5'b01000) return 64;
    if ((f[6:4] == 3'b110 && f[2]) || f[6:2] == 5'b11000 ||
        (!f[6] && f[4] && f[3:2] == 2'b00 && f[13:12] == 2'b01)) return 64;
    return 32;
  endfunction

  function automatic bit m_is_store(input logic [29:0] w);
    return w[4:0] == 5'b01000;
  endfunction

  function automatic bit m_is_mem(input logic [29:0] w);
    return (w[4:0] == 5'b01000) || (w[4:0] == 5'b00000);
  endfunction

  bit          m_idle = 1'b1;
  bit          m_bubble = 1'b1;
  bit          m_wait = 1'b0;
  bit          m_flush = 1'b0;
  logic [29:0] m_instr = NOP30;
  int          m_t = 0;

  // One clock: compare all outputs against the model, advance the model, cross the edge.
  task automatic cyc();
    logic [79:0] a, e;
    int len;
    bit mem, last;
    logic [4:0] ecnt;
    logic [2:0] ecyc;
    #1;
    len  = m_len(m_instr);
    mem  = m_is_mem(m_instr);
    last = !m_idle && !m_wait && (m_t == len - 1);
    ecnt = (m_idle || m_wait) ? 5'd0 : 5'(m_t % 32);
    ecyc = m_idle ? 3'd0 : m_wait ? 3'd1 : 3'(m_t / 32);
    a = {6'd0, fetch_ready, fetch_flush, instr, next_instr, counter, cycle,
         shift_data_out, mem_req, mem_we, instr_retired};
    e = {6'd0, (m_idle ? !m_flush : last), m_flush, m_instr,
         (fetch_valid ? fetch_data : NOP30), ecnt, ecyc,
         (!m_idle && !m_wait && mem && m_t >= 32 && m_t < 64),
         m_wait, (m_wait && m_is_store(m_instr)), (last && !m_bubble)};
    chk("model", a, e);
    if (!rstn) begin
      m_idle = 1; m_instr = NOP30; m_bubble = 1; m_t = 0; m_wait = 0; m_flush = 0;
    end else begin
      if (m_idle) begin
        if (fetch_valid && !m_flush) begin
          m_instr = fetch_data; m_bubble = 0; m_idle = 0; m_t = 0;
        end
      end else if (m_wait) begin
        if (mem_ack) m_wait = 0;
      end else if (mem && m_t == 31) begin
        m_wait = 1; m_t = 32;
      end else if (last) begin
        m_instr = fetch_valid ? fetch_data : NOP30; m_bubble = !fetch_valid; m_t = 0;
      end else begin
        m_t++;
      end
      m_flush = branch;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 0; fetch_valid = 0; fetch_data = '0; mem_ack = 0; branch = 0;
    cyc();
    rstn = 1;
  endtask

  typedef struct {
    logic [31:0] word;
    int          len;
    bit          req;
    bit          we;
  } vec_t;

  vec_t vt[14];
  logic [29:0] pool[14];

  initial begin
    int k, ret, ret1, ret2, n, shifts, flk, fl, badr, nonnop;
    bit saw, we, found;

    vt[0]  = '{32'h00500093, 32, 0, 0}; // ADDI
    vt[1]  = '{32'h123450B7, 32, 0, 0}; // LUI
    vt[2]  = '{32'h002081B3, 32, 0, 0}; // ADD
    vt[3]  = '{32'h0FF0C093, 32, 0, 0}; // XORI
    vt[4]  = '{32'h0010A093, 32, 0, 0}; // SLTI
    vt[5]  = '{32'h00309093, 64, 0, 0}; // SLLI
    vt[6]  = '{32'h4030D093, 64, 0, 0}; // SRAI
    vt[7]  = '{32'h002091B3, 64, 0, 0}; // SLL
    vt[8]  = '{32'h008000EF, 64, 0, 0}; // JAL
    vt[9]  = '{32'h000080E7, 64, 0, 0}; // JALR
    vt[10] = '{32'h00208463, 64, 0, 0}; // BEQ
    vt[11] = '{32'h0000A103, 97, 1, 0}; // LW, ack held high
    vt[12] = '{32'h0020A023, 65, 1, 1}; // SW, ack held high
    vt[13] = '{32'h0020B1B3, 32, 0, 0}; // SLTU
    for (int i = 0; i < 14; i++) pool[i] = vt[i].word[31:2];

    rstn = 0; fetch_valid = 0; fetch_data = '0; mem_ack = 0; branch = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk("rst_state", {fetch_ready, fetch_flush, shift_data_out, mem_req, mem_we,
                      instr_retired, counter, cycle, instr},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, NOP30});

    // Decode/latency table: clocks from first EXEC clock to retire.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      fetch_valid = 1; fetch_data = vt[i].word[31:2];
      cyc();
      fetch_valid = 0; mem_ack = 1;
      ret = 0; saw = 0; we = 0;
      for (int j = 1; j <= 200 && ret == 0; j++) begin
        if (mem_req) begin saw = 1; we = mem_we; end
        if (instr_retired) ret = j;
        cyc();
      end
      chk($sformatf("len_%0d", i), 80'(ret), 80'(vt[i].len));
      chk($sformatf("mem_%0d", i), {78'd0, saw, we}, {78'd0, vt[i].req, vt[i].we});
      chk($sformatf("nop_after_%0d", i), 80'(instr), 80'(NOP30));
    end

    // Back-to-back ADDI: retire at 32 and 64, fetch_ready only at counter 31.
    do_reset();
    fetch_valid = 1; fetch_data = vt[0].word[31:2]; mem_ack = 0;
    cyc();
    ret1 = 0; ret2 = 0; badr = 0;
    for (int j = 1; j <= 64; j++) begin
      if (instr_retired) begin if (ret1 == 0) ret1 = j; else ret2 = j; end
      if (fetch_ready && counter != 5'd31) badr++;
      cyc();
    end
    chk("b2b_ret1", 80'(ret1), 80'd32);
    chk("b2b_ret2", 80'(ret2), 80'd64);
    chk("b2b_ready_only_c31", 80'(badr), 80'd0);

    // LW with mem_req held for 5 clocks.
    do_reset();
    fetch_valid = 1; fetch_data = vt[11].word[31:2];
    cyc();
    fetch_valid = 0;
    n = 0; shifts = 0; ret = 0; badr = 0;
    for (int j = 1; j <= 200 && ret == 0; j++) begin
      if (mem_req) begin
        n++;
        if (mem_we || cycle != 3'd1) badr++;
      end
      mem_ack = mem_req && (n == 5);
      if (shift_data_out) shifts++;
      if (instr_retired) ret = j;
      cyc();
    end
    mem_ack = 0;
    chk("lw_req_clocks", 80'(n), 80'd5);
    chk("lw_req_we_cycle", 80'(badr), 80'd0);
    chk("lw_shift_clocks", 80'(shifts), 80'd32);
    chk("lw_retire", 80'(ret), 80'd101);

    // SW with immediate ack; next word starts right after retire.
    do_reset();
    fetch_valid = 1; fetch_data = vt[12].word[31:2];
    cyc();
    fetch_data = vt[1].word[31:2]; mem_ack = 1;
    shifts = 0; ret = 0; we = 0;
    for (int j = 1; j <= 200 && ret == 0; j++) begin
      if (mem_req) we = mem_we;
      if (shift_data_out) shifts++;
      if (instr_retired) ret = j;
      cyc();
    end
    chk("sw_we", 80'(we), 80'd1);
    chk("sw_shift_clocks", 80'(shifts), 80'd32);
    chk("sw_retire", 80'(ret), 80'd65);
    chk("sw_next_start", {instr, counter, cycle, shift_data_out},
        {vt[1].word[31:2], 5'd0, 3'd0, 1'b0});

    // Starved fetch: one NOP bubble pass, not retired, then real word loads.
    do_reset();
    fetch_valid = 1; fetch_data = vt[0].word[31:2];
    cyc();
    fetch_valid = 0;
    repeat (32) cyc();
    fetch_valid = 1; fetch_data = vt[2].word[31:2];
    n = 0; nonnop = 0;
    for (int j = 1; j <= 32; j++) begin
      if (instr_retired) n++;
      if (instr != NOP30) nonnop++;
      cyc();
    end
    chk("bubble_no_retire", 80'(n), 80'd0);
    chk("bubble_is_nop", 80'(nonnop), 80'd0);
    chk("bubble_then_load", 80'(instr), 80'(vt[2].word[31:2]));

    // JAL with branch at pass 0 / counter 0.
    do_reset();
    fetch_valid = 1; fetch_data = vt[8].word[31:2];
    cyc();
    fetch_data = vt[3].word[31:2];
    fl = 0; flk = 0; ret = 0;
    for (int j = 1; j <= 80 && ret == 0; j++) begin
      branch = (j == 1);
      if (fetch_flush) begin fl++; flk = j; end
      if (instr_retired) ret = j;
      cyc();
    end
    branch = 0;
    chk("jal_flush_count", 80'(fl), 80'd1);
    chk("jal_flush_clock", 80'(flk), 80'd2);
    chk("jal_retire", 80'(ret), 80'd64);
    chk("jal_next_word", 80'(instr), 80'(vt[3].word[31:2]));

    // Reset in the middle of MEM_SHIFT at counter 12.
    do_reset();
    fetch_valid = 1; fetch_data = vt[11].word[31:2];
    cyc();
    fetch_valid = 0; mem_ack = 1; found = 0;
    for (int j = 0; j < 200 && !found; j++) begin
      if (shift_data_out && counter == 5'd12) found = 1;
      else cyc();
    end
    chk("mid_shift_found", 80'(found), 80'd1);
    rstn = 0;
    cyc();
    rstn = 1; mem_ack = 0;
    chk("mid_shift_reset", {fetch_ready, fetch_flush, shift_data_out, mem_req, mem_we,
                            instr_retired, counter, cycle, instr},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, NOP30});

    // Randomized run checked clock-by-clock against the model.
    for (int j = 0; j < 4000; j++) begin
      rstn        = ($urandom_range(0, 599) != 0);
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_data  = pool[$urandom_range(0, 13)];
      mem_ack     = ($urandom_range(0, 9) < 3);
      branch      = ($urandom_range(0, 19) == 0);
      cyc();
    end
    rstn = 1; branch = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
